ysyx_23060096_wbu: RTL
======================

YSYX_23060096_WBU -- requirements
Module: ysyx_23060096_wbu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports exu_valid (input, 1), exu_ready (output, 1), exu_rd (input, ADDR_WIDTH), exu_data (input, DATA_WIDTH) and exu_wen (input, 1) for ALU results.
REQ-006 SHALL have ports lsu_valid (input, 1), lsu_ready (output, 1), lsu_rd (input, ADDR_WIDTH), lsu_rdata (input, 32, raw bus word), lsu_funct3 (input, 3) and lsu_addr_lo (input, 2) for load results.
REQ-007 SHALL have ports rf_wen (output, 1), rf_waddr (output, ADDR_WIDTH) and rf_wdata (output, DATA_WIDTH), the register-file write port.
REQ-008 SHALL have ports issue_valid (input, 1) and issue_rd (input, ADDR_WIDTH), destination claimed at issue.
REQ-009 SHALL have ports rs1 and rs2 (inputs, ADDR_WIDTH) and hazard (output, 1), operand-pending query.
REQ-010 SHALL have port retire (output, 1), a one-cycle pulse per completed writeback.

Function
REQ-011 SHALL accept a transfer when valid and ready are both high at a rising edge; ready SHALL NOT depend on the same channel's valid.
REQ-012 SHALL give LSU fixed priority: lsu_ready = 1; exu_ready = !lsu_valid.
REQ-013 SHALL register rf_wen/rf_waddr/rf_wdata/retire: one-cycle latency from acceptance; at most one write per cycle.
REQ-014 SHALL force rf_wen = 0 when the accepted rd is 0 or exu_wen is 0; retire SHALL still pulse.
REQ-015 SHALL extract load data: 000 LB sign-extends byte lsu_addr_lo; 001 LH sign-extends halfword lsu_addr_lo[1]; 010 LW passes the word; 100 LBU and 101 LHU zero-extend; other encodings pass the word.
REQ-016 SHALL keep a pending bit per register: set at the edge issue_valid && issue_rd != 0; cleared at the edge where rf_wen && rf_waddr matches; simultaneous set and clear on the same register leaves it set.
REQ-017 SHALL drive hazard = pending[rs1] | pending[rs2] combinationally; register 0 is never pending.
REQ-018 SHALL, when neither channel is accepted, drive rf_wen = 0 and retire = 0 the next cycle.

Reset
REQ-019 SHALL on rstn low immediately clear rf_wen, retire, rf_waddr, rf_wdata and all pending bits, discarding any in-flight write.
REQ-020 SHALL leave exu_ready = 1 and lsu_ready = 1 during and after reset, with no transfer accepted while rstn is low.

Configuration
REQ-021 SHALL, with YSYX_23060096_SCOREBOARD_EN defined, implement REQ-016/REQ-017.
REQ-022 SHALL, without YSYX_23060096_SCOREBOARD_EN, tie hazard to 0, ignore issue_* and include no pending storage.

Structure
REQ-023 SHALL take load funct3 encodings and ADDR_WIDTH/DATA_WIDTH defaults from the shared package ysyx_23060096_pkg.
REQ-024 SHALL place load extension in one combinational sub-module, ysyx_23060096_load_ext.

Verification
REQ-025 SHALL test: exu_valid, rd=5, data=0x1234_5678 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234_5678, retire=1.
REQ-026 SHALL test: exu and lsu valid together, lsu_rd=3 -> exu_ready=0, LSU written first, EXU written the cycle after.
REQ-027 SHALL test: LB, rdata=0x80FF_7F01, addr_lo=3 -> wdata 0xFFFF_FF80; LHU, addr_lo=2 -> wdata 0x0000_80FF.
REQ-028 SHALL test: exu rd=0, data=0xDEAD_BEEF -> rf_wen=0, retire=1.
REQ-029 SHALL test: issue rd=7, rs1=7 -> hazard=1 until the edge writing 7, then 0; issue rd=7 on that edge -> hazard stays 1.
REQ-030 SHALL test: rstn low mid-write -> rf_wen=0 at once and all pending bits cleared.

Source files
------------

// File: rtl/ysyx_23060096_pkg.sv
// Shared definitions for the writeback unit: width defaults and load funct3 encodings.
package ysyx_23060096_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // RISC-V load funct3 encodings; anything else is treated as a plain word
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_f3_e;

endpackage

// File: rtl/ysyx_23060096_wbu_load_ext.sv
// Load data extraction: pick byte/halfword lane from the raw bus word and extend.
module ysyx_23060096_load_ext
  import ysyx_23060096_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic [31:0]           rdata,
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then sign/zero extension by funct3
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data     = DATA_WIDTH'(rdata);
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_LBU:  data = DATA_WIDTH'(byte_sel);
      F3_LHU:  data = DATA_WIDTH'(half_sel);
      default: data = DATA_WIDTH'(rdata);
    endcase
  end

endmodule

// File: rtl/ysyx_23060096_wbu.sv
// Writeback unit: arbitrates EXU/LSU results onto the register-file write port.
// LSU has fixed priority. Optional pending-register scoreboard enabled by
// defining YSYX_23060096_SCOREBOARD_EN; otherwise hazard is tied low.
module ysyx_23060096_wbu
  import ysyx_23060096_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  exu_wen,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [31:0]           lsu_rdata,
  input  logic [2:0]            lsu_funct3,
  input  logic [1:0]            lsu_addr_lo,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  hazard,
  output logic                  retire
);

  logic [DATA_WIDTH-1:0] ld_data;
  logic                  exu_acc;
  logic                  rf_wen_d, rf_wen_q, retire_d, retire_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_d, rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_d, rf_wdata_q;

  ysyx_23060096_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
    .rdata   (lsu_rdata),
    .funct3  (lsu_funct3),
    .addr_lo (lsu_addr_lo),
    .data    (ld_data)
  );

  // LSU always accepted; EXU only when LSU is idle. Held high in reset.
  assign lsu_ready = 1'b1;
  assign exu_ready = !(rstn && lsu_valid);
  assign exu_acc   = exu_valid && exu_ready;

  // Select the winning channel; rd 0 or exu_wen=0 retires without writing
  always_comb begin
    rf_wen_d   = 1'b0;
    retire_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (lsu_valid) begin
      retire_d   = 1'b1;
      rf_wen_d   = (lsu_rd != '0);
      rf_waddr_d = lsu_rd;
      rf_wdata_d = ld_data;
    end else if (exu_acc) begin
      retire_d   = 1'b1;
      rf_wen_d   = exu_wen && (exu_rd != '0);
      rf_waddr_d = exu_rd;
      rf_wdata_d = exu_data;
    end
  end

  // Registered write port; reset discards any in-flight write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_wen_q   <= 1'b0;
      retire_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      retire_q   <= retire_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign retire   = retire_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef YSYX_23060096_SCOREBOARD_EN
  localparam int NREG = 1 << ADDR_WIDTH;
  logic [NREG-1:0] pend_d, pend_q;

  // Clear on write, then set on issue so a same-edge reissue wins
  always_comb begin
    pend_d = pend_q;
    if (rf_wen_q) pend_d[rf_waddr_q] = 1'b0;
    if (issue_valid && issue_rd != '0) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Pending-bit storage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign hazard = pend_q[rs1] | pend_q[rs2];
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_rd, rs1, rs2};
  assign hazard       = 1'b0;
`endif

endmodule
